// File: rtl/fwd_pkg.sv
// Shared types and constants for the result staging / operand forwarding path.
// Packet layout, MSB first: data, lat, we, rt.
package fwd_pkg;

    localparam int unsigned NUM_STAGES = 7;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned LAT_W      = 3;
    localparam int unsigned ADDR_W     = 7;

    localparam int unsigned PKT_W = DATA_W + LAT_W + 1 + ADDR_W;

    // Bit positions of each field inside a flattened packet (LSB numbering).
    localparam int unsigned PKT_RT_LSB   = 0;
    localparam int unsigned PKT_RT_MSB   = ADDR_W - 1;
    localparam int unsigned PKT_WE_BIT   = ADDR_W;
    localparam int unsigned PKT_LAT_LSB  = ADDR_W + 1;
    localparam int unsigned PKT_LAT_MSB  = ADDR_W + LAT_W;
    localparam int unsigned PKT_DATA_LSB = ADDR_W + LAT_W + 1;
    localparam int unsigned PKT_DATA_MSB = PKT_W - 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LAT_W-1:0]  lat;
        logic              we;
        logic [ADDR_W-1:0] rt;
    } fw_pkt_t;

    // Packet entering stage 1 for a new issue; a zero latency can never be merged, so it never writes.
    function automatic fw_pkt_t issue_pkt(logic we, logic [LAT_W-1:0] lat, logic [ADDR_W-1:0] rt);
        fw_pkt_t p;
        p      = '0;
        p.lat  = lat;
        p.we   = we && (lat != '0);
        p.rt   = rt;
        return p;
    endfunction

endpackage

// File: rtl/fw_stage_reg.sv
// One forwarding/writeback stage register.
// Ports: clk, rst_n; in_pkt (packet shifting in), merge_en/merge_data (result
// replaces data), flush_en (clears we of the incoming packet); pkt_q (stage contents).
module fw_stage_reg
    import fwd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  fw_pkt_t           in_pkt,
    input  logic              merge_en,
    input  logic [DATA_W-1:0] merge_data,
    input  logic              flush_en,
    output fw_pkt_t           pkt_q
);

    fw_pkt_t pkt_d;

    // Merge and flush act on the value being written, not on the held value.
    always_comb begin
        pkt_d = in_pkt;
        if (merge_en) begin
            pkt_d.data = merge_data;
        end
        if (flush_en) begin
            pkt_d.we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

endmodule

// File: rtl/fw_result_pipe.sv
// Per-pipe result staging pipeline feeding operand forwarding and RF writeback.
// Inputs : clk, rst_n, issue (iss_valid/we/lat/rt), result (res_valid/lat/data),
//          flush/flush_upto.
// Outputs: fw_out[1:7] stage packets, wb_out writeback packet, rf_we,
//          err_res / err_miss / err_iss one-cycle error pulses.
module fw_result_pipe
    import fwd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic              iss_we,
    input  logic [LAT_W-1:0]  iss_lat,
    input  logic [ADDR_W-1:0] iss_rt,
    input  logic              res_valid,
    input  logic [LAT_W-1:0]  res_lat,
    input  logic [DATA_W-1:0] res_data,
    input  logic              flush,
    input  logic [LAT_W-1:0]  flush_upto,
    output fw_pkt_t           fw_out [1:NUM_STAGES],
    output fw_pkt_t           wb_out,
    output logic              rf_we,
    output logic              err_res,
    output logic              err_miss,
    output logic              err_iss
);

    localparam int unsigned WB_IDX = NUM_STAGES + 1;

    fw_pkt_t stage_in [1:WB_IDX];
    fw_pkt_t stage_q  [1:WB_IDX];
    logic    merge_en [1:WB_IDX];
    logic    flush_en [1:WB_IDX];

    logic err_res_d,  err_res_q;
    logic err_miss_d, err_miss_q;
    logic err_iss_d,  err_iss_q;

    // Shift network, result merge, flush gating and error detection.
    always_comb begin
        logic is_tgt;
        logic is_flushed;
        logic is_due;

        is_tgt     = 1'b0;
        is_flushed = 1'b0;
        is_due     = 1'b0;
        err_res_d  = 1'b0;
        err_miss_d = 1'b0;
        err_iss_d  = iss_valid && (iss_lat == '0);

        stage_in[1] = iss_valid ? issue_pkt(iss_we, iss_lat, iss_rt) : '0;
        for (int k = 2; k <= WB_IDX; k++) begin
            stage_in[k] = stage_q[k-1];
        end
        for (int k = 1; k <= WB_IDX; k++) begin
            merge_en[k] = 1'b0;
            flush_en[k] = 1'b0;
        end

        // A latency-L result always lands in the packet moving into stage L.
        for (int k = 1; k <= NUM_STAGES; k++) begin
            is_tgt     = res_valid && (res_lat == LAT_W'(k));
            is_flushed = flush && (flush_upto >= LAT_W'(k));
            is_due     = stage_in[k].we && (stage_in[k].lat == LAT_W'(k));

            merge_en[k] = is_tgt && is_due;
            flush_en[k] = is_flushed;

            // A flushed target is dead, so neither a stray result nor a missing one is reported.
            if (is_tgt && !is_due && !is_flushed) begin
                err_res_d = 1'b1;
            end
            if (is_due && !is_tgt && !is_flushed) begin
                err_miss_d = 1'b1;
            end
        end

        if (res_valid && (res_lat == '0)) begin
            err_res_d = 1'b1;
        end
    end

    for (genvar g = 1; g <= WB_IDX; g++) begin : g_stage
        fw_stage_reg u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_pkt     (stage_in[g]),
            .merge_en   (merge_en[g]),
            .merge_data (res_data),
            .flush_en   (flush_en[g]),
            .pkt_q      (stage_q[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_res_q  <= 1'b0;
            err_miss_q <= 1'b0;
            err_iss_q  <= 1'b0;
        end else begin
            err_res_q  <= err_res_d;
            err_miss_q <= err_miss_d;
            err_iss_q  <= err_iss_d;
        end
    end

    for (genvar g = 1; g <= NUM_STAGES; g++) begin : g_out
        assign fw_out[g] = stage_q[g];
    end

    assign wb_out   = stage_q[WB_IDX];
    assign rf_we    = stage_q[WB_IDX][PKT_WE_BIT];
    assign err_res  = err_res_q;
    assign err_miss = err_miss_q;
    assign err_iss  = err_iss_q;

endmodule

// File: tb/tb_fw_result_pipe.sv
// Self-checking bench for fw_result_pipe: per-cycle vector table plus a
// writeback scoreboard, and a hand-written asynchronous reset sequence.
module tb_fw_result_pipe;
    import fwd_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              iss_valid;
    logic              iss_we;
    logic [LAT_W-1:0]  iss_lat;
    logic [ADDR_W-1:0] iss_rt;
    logic              res_valid;
    logic [LAT_W-1:0]  res_lat;
    logic [DATA_W-1:0] res_data;
    logic              flush;
    logic [LAT_W-1:0]  flush_upto;
    fw_pkt_t           fw_out [1:NUM_STAGES];
    fw_pkt_t           wb_out;
    logic              rf_we;
    logic              err_res;
    logic              err_miss;
    logic              err_iss;

    fw_result_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_valid  (iss_valid),
        .iss_we     (iss_we),
        .iss_lat    (iss_lat),
        .iss_rt     (iss_rt),
        .res_valid  (res_valid),
        .res_lat    (res_lat),
        .res_data   (res_data),
        .flush      (flush),
        .flush_upto (flush_upto),
        .fw_out     (fw_out),
        .wb_out     (wb_out),
        .rf_we      (rf_we),
        .err_res    (err_res),
        .err_miss   (err_miss),
        .err_iss    (err_iss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per clock: inputs before the edge, expectations just after it.
    // e_err = {err_res, err_miss, err_iss}; stg 1..7 = fw_out, 8 = wb_out, 0 = none.
    typedef struct {
        logic         iv;
        logic         iwe;
        logic [2:0]   ilat;
        logic [6:0]   irt;
        logic         rv;
        logic [2:0]   rlat;
        logic [127:0] rd;
        logic         fl;
        logic [2:0]   fu;
        logic [2:0]   e_err;
        int           stg;
        fw_pkt_t      ep;
        logic         push;
        logic [127:0] wbd;
    } vec_t;

    vec_t    tbl [$];
    fw_pkt_t sb  [$];
    int      n_vec = 0;
    int      n_bad = 0;

    function automatic fw_pkt_t mk(logic [127:0] d, logic [2:0] l, logic w, logic [6:0] r);
        fw_pkt_t p;
        p.data = d;
        p.lat  = l;
        p.we   = w;
        p.rt   = r;
        return p;
    endfunction

    function automatic logic [127:0] rep(logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic fw_pkt_t stage_of(int s);
        if (s == NUM_STAGES + 1) return wb_out;
        return fw_out[s];
    endfunction

    task automatic add(logic iv, logic iwe, logic [2:0] ilat, logic [6:0] irt,
                       logic rv, logic [2:0] rlat, logic [127:0] rd,
                       logic fl, logic [2:0] fu, logic [2:0] e_err,
                       int stg, fw_pkt_t ep, logic push, logic [127:0] wbd);
        vec_t v;
        v.iv = iv; v.iwe = iwe; v.ilat = ilat; v.irt = irt;
        v.rv = rv; v.rlat = rlat; v.rd = rd; v.fl = fl; v.fu = fu;
        v.e_err = e_err; v.stg = stg; v.ep = ep; v.push = push; v.wbd = wbd;
        tbl.push_back(v);
    endtask

    task automatic idle(int n);
        repeat (n) add(0, 0, 0, 0, 0, 0, '0, 0, 0, 3'b000, 0, '0, 0, '0);
    endtask

    task automatic chk(logic [2:0] e_err, int stg, fw_pkt_t ep);
        add(0, 0, 0, 0, 0, 0, '0, 0, 0, e_err, stg, ep, 0, '0);
    endtask

    task automatic drive(logic iv, logic iwe, logic [2:0] ilat, logic [6:0] irt,
                         logic rv, logic [2:0] rlat, logic [127:0] rd,
                         logic fl, logic [2:0] fu);
        iss_valid = iv; iss_we = iwe; iss_lat = ilat; iss_rt = irt;
        res_valid = rv; res_lat = rlat; res_data = rd;
        flush = fl; flush_upto = fu;
    endtask

    task automatic cmp_pkt(string nm, fw_pkt_t act, fw_pkt_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got data=%h lat=%0d we=%b rt=%0d, want data=%h lat=%0d we=%b rt=%0d",
                     nm, act.data, act.lat, act.we, act.rt, exp.data, exp.lat, exp.we, exp.rt);
        end
    endtask

    task automatic cmp_val(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(string nm);
        for (int s = 1; s <= NUM_STAGES + 1; s++) begin
            cmp_pkt($sformatf("%s stage %0d", nm, s), stage_of(s), '0);
        end
        cmp_val({nm, " rf_we/err"}, 32'({rf_we, err_res, err_miss, err_iss}), 32'd0);
    endtask

    // Writeback monitor: every rf_we must match the oldest expected writeback.
    always @(posedge clk) begin
        fw_pkt_t exp;
        #1;
        cmp_val("rf_we vs wb_out.we", 32'(rf_we), 32'(wb_out.we));
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected writeback: got rt=%0d data=%h, want no writeback",
                         wb_out.rt, wb_out.data);
            end else begin
                exp = sb.pop_front();
                cmp_pkt("writeback", wb_out, exp);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, '0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic lat=2 merge and writeback.
        add(1, 1, 2, 5, 0, 0, '0, 0, 0, 3'b000, 1, mk('0, 2, 1, 5), 1, rep(8'hA5));
        add(0, 0, 0, 0, 1, 2, rep(8'hA5), 0, 0, 3'b000, 2, mk(rep(8'hA5), 2, 1, 5), 0, '0);
        idle(4);
        chk(3'b000, 7, mk(rep(8'hA5), 2, 1, 5));
        chk(3'b000, 8, mk(rep(8'hA5), 2, 1, 5));
        chk(3'b000, 8, '0);
        // lat=4 with no result: miss at stage 4, writes back zero.
        add(1, 1, 4, 9, 0, 0, '0, 0, 0, 3'b000, 1, mk('0, 4, 1, 9), 1, '0);
        idle(2);
        chk(3'b010, 4, mk('0, 4, 1, 9));
        idle(1);
        // lat=3 result aimed at a lat=6 entry: dropped, then the entry misses.
        add(1, 1, 6, 12, 0, 0, '0, 0, 0, 3'b000, 1, mk('0, 6, 1, 12), 1, '0);
        idle(1);
        add(0, 0, 0, 0, 1, 3, rep(8'h3C), 0, 0, 3'b100, 3, mk('0, 6, 1, 12), 0, '0);
        idle(2);
        chk(3'b010, 6, mk('0, 6, 1, 12));
        idle(2);
        // Latency-0 issue, latency-0 result, orphan result.
        add(1, 1, 0, 3, 0, 0, '0, 0, 0, 3'b001, 1, mk('0, 0, 0, 3), 0, '0);
        add(0, 0, 0, 0, 1, 0, rep(8'h77), 0, 0, 3'b100, 0, '0, 0, '0);
        add(0, 0, 0, 0, 1, 5, rep(8'h55), 0, 0, 3'b100, 5, '0, 0, '0);
        idle(1);
        // Flush of post-shift stages 1..3 with a merge into a flushed stage.
        add(1, 1, 1, 20, 1, 1, rep(8'h11), 0, 0, 3'b000, 1, mk(rep(8'h11), 1, 1, 20), 1, rep(8'h11));
        add(1, 1, 1, 21, 1, 1, rep(8'h22), 0, 0, 3'b000, 1, mk(rep(8'h22), 1, 1, 21), 1, rep(8'h22));
        add(1, 1, 6, 22, 0, 0, '0, 0, 0, 3'b000, 1, mk('0, 6, 1, 22), 0, '0);
        add(1, 1, 2, 23, 0, 0, '0, 0, 0, 3'b000, 4, mk(rep(8'h11), 1, 1, 20), 0, '0);
        add(0, 0, 0, 0, 1, 2, rep(8'h44), 1, 3, 3'b000, 2, mk(rep(8'h44), 2, 0, 23), 0, '0);
        chk(3'b000, 4, mk('0, 6, 0, 22));
        idle(1);
        chk(3'b000, 6, mk('0, 6, 0, 22));
        idle(1);
        chk(3'b000, 8, mk('0, 6, 0, 22));
        chk(3'b000, 8, mk(rep(8'h44), 2, 0, 23));
        // Back-to-back lat=1 issues rt=1..7.
        for (int i = 1; i <= 7; i++) begin
            add(1, 1, 1, 7'(i), 1, 1, rep(8'(i * 17)), 0, 0, 3'b000, 1,
                mk(rep(8'(i * 17)), 1, 1, 7'(i)), 1, rep(8'(i * 17)));
        end
        idle(8);

        for (int r = 0; r < tbl.size(); r++) begin
            vec_t v;
            v = tbl[r];
            @(negedge clk);
            drive(v.iv, v.iwe, v.ilat, v.irt, v.rv, v.rlat, v.rd, v.fl, v.fu);
            if (v.push) sb.push_back(mk(v.wbd, v.ilat, 1'b1, v.irt));
            @(posedge clk);
            #1;
            cmp_val($sformatf("row %0d err{res,miss,iss}", r),
                    32'({err_res, err_miss, err_iss}), 32'(v.e_err));
            if (v.stg != 0) begin
                cmp_pkt($sformatf("row %0d stage %0d", r, v.stg), stage_of(v.stg), v.ep);
            end
        end

        // Reset mid-flight: outputs clear at once and nothing in flight writes back.
        @(negedge clk);
        drive(1, 1, 1, 30, 1, 1, rep(8'hFF), 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1, 0, 31, 0, 0, '0, 0, 0);
        @(posedge clk);
        #1;
        cmp_val("err_iss before reset", 32'(err_iss), 32'd1);
        cmp_pkt("stage 2 before reset", fw_out[2], mk(rep(8'hFF), 1, 1, 30));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, '0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_all_zero("after reset idle");

        // Fresh lat=3 issue after release.
        @(negedge clk);
        drive(1, 1, 3, 40, 0, 0, '0, 0, 0);
        sb.push_back(mk(rep(8'hC3), 3, 1'b1, 40));
        @(posedge clk);
        #1;
        cmp_pkt("post-reset issue stage 1", fw_out[1], mk('0, 3, 1, 40));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, '0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 3, rep(8'hC3), 0, 0);
        @(posedge clk);
        #1;
        cmp_pkt("post-reset merge stage 3", fw_out[3], mk(rep(8'hC3), 3, 1, 40));
        cmp_val("post-reset err{res,miss,iss}", 32'({err_res, err_miss, err_iss}), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, '0, 0, 0);
        repeat (8) @(posedge clk);
        #2;
        cmp_val("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
